// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// MEM-stage store engine for the multicycle core. Performs SB/SH/SW against a
// 32-bit word memory. Word stores are written directly. Byte and halfword
// stores read the target word, replace its low byte/halfword with register
// data, and write the merged word back.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request strobe, sampled only while idle
//   SS_control in   store size: 00 none, 01 SB, 10 SH, 11 SW
//   Address    in   byte address of the target word (passed through unchanged)
//   Reg_data   in   rs2 value to store
//   Mem_rdata  in   memory read data, valid MEM_LATENCY cycles after Mem_addr
//   Mem_addr   out  memory address (registered)
//   Mem_wr     out  memory write enable, one-cycle pulse (registered)
//   Mem_wdata  out  memory write data (registered)
//   busy       out  high in every state except IDLE (registered)
//   done       out  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  SS_control,
    input  logic [31:0] Address,
    input  logic [31:0] Reg_data,
    input  logic [31:0] Mem_rdata,
    output logic [31:0] Mem_addr,
    output logic        Mem_wr,
    output logic [31:0] Mem_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_B    = 2'b01;
    localparam logic [1:0] SZ_H    = 2'b10;
    localparam logic [1:0] SZ_W    = 2'b11;

    // Out-of-range latencies are clamped into 1..4 so the counter never wraps.
    localparam int LAT_CLAMP = (MEM_LATENCY < 1) ? 1 :
                               ((MEM_LATENCY > 4) ? 4 : MEM_LATENCY);
    // The counter is loaded at accept and the read finishes when it reads zero,
    // giving exactly MEM_LATENCY cycles in READ.
    localparam logic [2:0] LAT_LOAD = 3'(LAT_CLAMP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Merge register data into the low lane of the word read from memory.
    // The lane position matches the load unit's extraction (bits 7:0 / 15:0).
    function automatic logic [31:0] merge_word(
        input logic [1:0]  size,
        input logic [31:0] rdata,
        input logic [15:0] data
    );
        logic [31:0] word;
        case (size)
            SZ_B:    word = {rdata[31:8],  data[7:0]};
            SZ_H:    word = {rdata[31:16], data[15:0]};
            default: word = rdata;
        endcase
        return word;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  cnt_r,   cnt_s;
    logic [1:0]  size_r,  size_s;
    logic [15:0] data_r,  data_s;
    logic [31:0] addr_r,  addr_s;
    logic        wr_r,    wr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        busy_r,  busy_s;
    logic        done_r,  done_s;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        size_s  = size_r;
        data_s  = data_r;
        addr_s  = addr_r;
        wr_s    = 1'b0;
        wdata_s = wdata_r;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    size_s = SS_control;
                    // Only the low halfword is ever merged; SW takes the full
                    // word straight from Reg_data at accept.
                    data_s = Reg_data[15:0];
                    addr_s = Address;
                    cnt_s  = LAT_LOAD;
                    case (SS_control)
                        SZ_NONE: begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end
                        SZ_W: begin
                            state_s = ST_WRITE;
                            wr_s    = 1'b1;
                            wdata_s = Reg_data;
                        end
                        SZ_B:    state_s = ST_READ;
                        SZ_H:    state_s = ST_READ;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // Mem_rdata is sampled only on the final READ edge.
                if (cnt_r == 3'd0) begin
                    state_s = ST_WRITE;
                    wr_s    = 1'b1;
                    wdata_s = merge_word(size_r, Mem_rdata, data_r);
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_WRITE: begin
                state_s = ST_DONE;
                done_s  = 1'b1;
            end
            ST_DONE: begin
                // start is deliberately not looked at on this edge.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs; reset aborts any request without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            size_r  <= 2'b00;
            data_r  <= 16'd0;
            addr_r  <= 32'd0;
            wr_r    <= 1'b0;
            wdata_r <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            size_r  <= size_s;
            data_r  <= data_s;
            addr_r  <= addr_s;
            wr_r    <= wr_s;
            wdata_r <= wdata_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign Mem_addr  = addr_r;
    assign Mem_wr    = wr_r;
    assign Mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;

    store_merge_unit_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .mem_wr (wr_r),
        .busy   (busy_r),
        .done   (done_r)
    );

endmodule

// -----------------------------------------------------------------------------
// store_merge_unit_chk
//
// Protocol properties of the store engine's output pulses.
// Ports: clk, reset, mem_wr, busy, done (all inputs, observed only).
// -----------------------------------------------------------------------------
module store_merge_unit_chk (
    input logic clk,
    input logic reset,
    input logic mem_wr,
    input logic busy,
    input logic done
);

    a_wr_single : assert property (@(posedge clk) disable iff (reset)
        mem_wr |=> !mem_wr)
        else $error("store_merge_unit: write pulse longer than one cycle");

    a_wr_busy : assert property (@(posedge clk) disable iff (reset)
        mem_wr |-> busy)
        else $error("store_merge_unit: write while not busy");

    a_done_busy : assert property (@(posedge clk) disable iff (reset)
        done |-> busy)
        else $error("store_merge_unit: done while not busy");

    a_wr_done_excl : assert property (@(posedge clk) disable iff (reset)
        !(mem_wr && done))
        else $error("store_merge_unit: write and done together");

endmodule

// File: tb/tb_store_merge_unit.sv
// -----------------------------------------------------------------------------
// tb_store_merge_unit
//
// Two instances (MEM_LATENCY 1 and 3) share clock and reset. A small word
// memory per instance answers reads and absorbs writes. Each request pushes
// its expected write and done events (cycle, address, data) into scoreboard
// queues; a monitor on the falling edge pops and compares whatever the DUTs
// present and also checks busy and Mem_addr against the expected window.
// -----------------------------------------------------------------------------
module tb_store_merge_unit;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start   [2];
    logic [1:0]  sz      [2];
    logic [31:0] addr    [2];
    logic [31:0] regd    [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_addr  [2];
    logic        m_wr    [2];
    logic [31:0] m_wdata [2];
    logic        busy    [2];
    logic        done    [2];

    logic [31:0] mem     [2][64];
    logic        ovr     [2];
    logic [31:0] ovr_val [2];
    logic        clr_mem;
    logic        pl_en;
    int          pl_i;
    logic [5:0]  pl_idx;
    logic [31:0] pl_v;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } wr_exp_t;
    typedef struct {
        int inst;
        int cyc;
    } dn_exp_t;

    wr_exp_t     wr_q[$];
    dn_exp_t     dn_q[$];
    int          cur_acc  [2];
    int          cur_done [2];
    logic [31:0] cur_addr [2];

    store_merge_unit #(.MEM_LATENCY(LAT0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .start      (start[0]),
        .SS_control (sz[0]),
        .Address    (addr[0]),
        .Reg_data   (regd[0]),
        .Mem_rdata  (m_rdata[0]),
        .Mem_addr   (m_addr[0]),
        .Mem_wr     (m_wr[0]),
        .Mem_wdata  (m_wdata[0]),
        .busy       (busy[0]),
        .done       (done[0])
    );

    store_merge_unit #(.MEM_LATENCY(LAT1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start[1]),
        .SS_control (sz[1]),
        .Address    (addr[1]),
        .Reg_data   (regd[1]),
        .Mem_rdata  (m_rdata[1]),
        .Mem_addr   (m_addr[1]),
        .Mem_wr     (m_wr[1]),
        .Mem_wdata  (m_wdata[1]),
        .busy       (busy[1]),
        .done       (done[1])
    );

    // Word memories: read data follows the address unless overridden with garbage.
    assign m_rdata[0] = ovr[0] ? ovr_val[0] : mem[0][m_addr[0][7:2]];
    assign m_rdata[1] = ovr[1] ? ovr_val[1] : mem[1][m_addr[1][7:2]];

    // Cycle counter: cycle N is the interval after the N-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory update: clear, preload from the bench, and DUT writes.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 64; j++)
                    mem[i][j] <= 32'd0;
        end else begin
            if (pl_en) mem[pl_i][pl_idx] <= pl_v;
            for (int i = 0; i < 2; i++)
                if (m_wr[i] === 1'b1) mem[i][m_addr[i][7:2]] <= m_wdata[i];
        end
    end

    // Scoreboard monitor: compare every presented output against expectations.
    always @(negedge clk) begin : mon
        logic exp_busy;
        int   k;
        for (int i = 0; i < 2; i++) begin
            exp_busy = (cyc >= cur_acc[i]) && (cyc <= cur_done[i]);
            n_cmp++;
            if (busy[i] !== exp_busy) begin
                n_bad++;
                $display("FAIL busy inst%0d cyc%0d: got %b want %b", i, cyc, busy[i], exp_busy);
            end
            if (exp_busy) begin
                n_cmp++;
                if (m_addr[i] !== cur_addr[i]) begin
                    n_bad++;
                    $display("FAIL mem_addr inst%0d cyc%0d: got %h want %h", i, cyc, m_addr[i], cur_addr[i]);
                end
            end
            if (m_wr[i] === 1'b1) begin
                k = -1;
                foreach (wr_q[j]) if (k < 0 && wr_q[j].inst == i) k = j;
                n_cmp++;
                if (k < 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write inst%0d cyc%0d: got addr %h data %h want none", i, cyc, m_addr[i], m_wdata[i]);
                end else begin
                    if (wr_q[k].cyc != cyc || wr_q[k].a !== m_addr[i] || wr_q[k].d !== m_wdata[i]) begin
                        n_bad++;
                        $display("FAIL write inst%0d: got cyc%0d addr %h data %h want cyc%0d addr %h data %h",
                                 i, cyc, m_addr[i], m_wdata[i], wr_q[k].cyc, wr_q[k].a, wr_q[k].d);
                    end
                    wr_q.delete(k);
                end
            end
            if (done[i] === 1'b1) begin
                k = -1;
                foreach (dn_q[j]) if (k < 0 && dn_q[j].inst == i) k = j;
                n_cmp++;
                if (k < 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done inst%0d cyc%0d: got done want none", i, cyc);
                end else begin
                    if (dn_q[k].cyc != cyc) begin
                        n_bad++;
                        $display("FAIL done_cycle inst%0d: got cyc%0d want cyc%0d", i, cyc, dn_q[k].cyc);
                    end
                    dn_q.delete(k);
                end
            end
        end
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic preload(input int i, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_i   = i;
        pl_idx = a[7:2];
        pl_v   = v;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    task automatic check_word(input int i, input logic [31:0] a, input logic [31:0] want, input string name);
        n_cmp++;
        if (mem[i][a[7:2]] !== want) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h want %h", name, i, mem[i][a[7:2]], want);
        end
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({m_addr[i], m_wr[i], m_wdata[i], busy[i], done[i]} !== 67'd0) begin
                n_bad++;
                $display("FAIL reset_state inst%0d: got addr %h wr %b wdata %h busy %b done %b want all zero",
                         i, m_addr[i], m_wr[i], m_wdata[i], busy[i], done[i]);
            end
        end
    endtask

    // Issue one request; expectations come from the size/latency rules and a
    // mask-and-or merge of the word currently in the bench memory.
    task automatic issue(input int i, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input bit garb, input bit poke);
        int          t;
        int          c1;
        int          wcyc;
        int          dcyc;
        logic [31:0] old;
        logic [31:0] exp_w;
        logic [31:0] gv;
        @(negedge clk);
        t = 0;
        while (busy[i] !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait inst%0d: got busy after %0d cycles want idle", i, t);
        end
        c1  = cyc + 1;
        gv  = $urandom;
        old = garb ? gv : mem[i][a[7:2]];
        case (s)
            2'b01:   exp_w = (old & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
            2'b10:   exp_w = (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
            default: exp_w = d;
        endcase
        if (s == 2'b00) begin
            wcyc = -10;
            dcyc = c1;
        end else if (s == 2'b11) begin
            wcyc = c1;
            dcyc = c1 + 1;
        end else begin
            wcyc = c1 + lat_of(i);
            dcyc = c1 + lat_of(i) + 1;
        end
        if (s != 2'b00) wr_q.push_back('{inst: i, cyc: wcyc, a: a, d: exp_w});
        dn_q.push_back('{inst: i, cyc: dcyc});
        cur_acc[i]  = c1;
        cur_done[i] = dcyc;
        cur_addr[i] = a;
        start[i] = 1'b1;
        sz[i]    = s;
        addr[i]  = a;
        regd[i]  = d;
        @(negedge clk);
        start[i] = 1'b0;
        sz[i]    = 2'($urandom);
        addr[i]  = $urandom;
        regd[i]  = $urandom;
        while (busy[i] === 1'b1 && cyc <= dcyc + 2) begin
            if (garb && cyc == wcyc - 1) begin
                ovr[i]     = 1'b1;
                ovr_val[i] = gv;
            end else begin
                ovr[i] = 1'b0;
            end
            if (poke) begin
                start[i] = 1'($urandom_range(0, 1));
                sz[i]    = 2'($urandom);
            end
            @(negedge clk);
        end
        start[i] = 1'b0;
        ovr[i]   = 1'b0;
    endtask

    initial begin : stim
        int c1;
        for (int i = 0; i < 2; i++) begin
            start[i]    = 1'b0;
            sz[i]       = 2'b00;
            addr[i]     = 32'd0;
            regd[i]     = 32'd0;
            ovr[i]      = 1'b0;
            ovr_val[i]  = 32'd0;
            cur_acc[i]  = -100;
            cur_done[i] = -100;
            cur_addr[i] = 32'd0;
        end
        pl_en   = 1'b0;
        pl_i    = 0;
        pl_idx  = 6'd0;
        pl_v    = 32'd0;
        clr_mem = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        clr_mem = 1'b0;
        check_reset_state();
        reset = 1'b0;

        // SB and SH with latency 1 on the reference word
        preload(0, 32'h40, 32'hAABBCCDD);
        issue(0, 2'b01, 32'h40, 32'h12345678, 1'b0, 1'b0);
        check_word(0, 32'h40, 32'hAABBCC78, "sb_word");
        preload(0, 32'h40, 32'hAABBCCDD);
        issue(0, 2'b10, 32'h40, 32'h12345678, 1'b0, 1'b0);
        check_word(0, 32'h40, 32'hAABB5678, "sh_word");

        // SH with latency 3, then with read data corrupted before the last READ edge
        preload(1, 32'h40, 32'hAABBCCDD);
        issue(1, 2'b10, 32'h40, 32'h12345678, 1'b0, 1'b0);
        check_word(1, 32'h40, 32'hAABB5678, "sh_lat3_word");
        preload(1, 32'h44, 32'h11223344);
        issue(1, 2'b10, 32'h44, 32'hCAFE9876, 1'b1, 1'b0);

        // SW direct write
        issue(0, 2'b11, 32'h80, 32'hDEADBEEF, 1'b0, 1'b0);
        check_word(0, 32'h80, 32'hDEADBEEF, "sw_word");

        // Size 00 and starts pulsed while busy
        issue(0, 2'b00, 32'h0000_0104, 32'h5555AAAA, 1'b0, 1'b1);
        issue(1, 2'b00, 32'h0000_0208, 32'hAAAA5555, 1'b0, 1'b1);
        issue(0, 2'b01, 32'h0000_0033, 32'h87654321, 1'b0, 1'b1);
        issue(1, 2'b11, 32'h0000_00F0, 32'h13579BDF, 1'b0, 1'b1);
        issue(1, 2'b01, 32'h0000_0011, 32'h2468ACE0, 1'b0, 1'b1);

        // Reset on the edge that would enter WRITE for an SB: no write, no done
        @(negedge clk);
        c1 = cyc + 1;
        cur_acc[0]  = c1;
        cur_done[0] = c1;
        cur_addr[0] = 32'h40;
        start[0] = 1'b1;
        sz[0]    = 2'b01;
        addr[0]  = 32'h40;
        regd[0]  = 32'h12345678;
        @(negedge clk);
        start[0] = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b0 || m_wr[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: got busy %b wr %b done %b want 0 0 0", busy[0], m_wr[0], done[0]);
        end
        @(negedge clk);
        issue(0, 2'b11, 32'h0000_0088, 32'h0BADF00D, 1'b0, 1'b0);
        check_word(0, 32'h88, 32'h0BADF00D, "sw_after_abort");

        // Reset and start together: the request is dropped
        @(negedge clk);
        reset    = 1'b1;
        start[1] = 1'b1;
        sz[1]    = 2'b11;
        addr[1]  = 32'h0000_0010;
        regd[1]  = 32'hFEEDFACE;
        @(negedge clk);
        reset    = 1'b0;
        start[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_with_start: got busy %b want 0", busy[1]);
        end

        // Randomized requests
        repeat (60) begin
            issue(int'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Drain and confirm every expected event was seen
        repeat (10) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != 0 || dn_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: got %0d writes %0d dones outstanding want 0 0", wr_q.size(), dn_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load size/zero-extend unit: performs SB/SH/SW into the 32-bit word memory of the multicycle processor.
- Word stores write directly. Byte and halfword stores do a read-modify-write: read the word at Address, replace the low byte or halfword with register data, write the word back.
- Sits between the control unit (start/done handshake) and the data memory port, in the MEM stage of the multicycle datapath.

Parameters:
MEM_LATENCY, 1, cycles from Mem_addr stable (read) to Mem_rdata valid; legal range 1..4.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
SS_control  in  2  store size: 00 none, 01 SB, 10 SH, 11 SW
Address  in  32  byte address of target word
Reg_data  in  32  rs2 value to store
Mem_rdata  in  32  memory read data
Mem_addr  out  32  memory address (registered)
Mem_wr  out  1  memory write enable (registered, one-cycle pulse)
Mem_wdata  out  32  memory write data (registered)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- All state and outputs update on rising clk only. reset=1 at an edge forces:
  - state=IDLE
  - Mem_addr=0, Mem_wr=0, Mem_wdata=0
  - busy=0, done=0
  - internal latches and latency counter to 0
- States:
  - IDLE: waits for start.
  - READ: Mem_wr=0, Mem_addr=latched address; counter runs MEM_LATENCY cycles.
  - WRITE: Mem_wr=1 for exactly one cycle; Mem_wdata holds the merged or direct word.
  - DONE: done=1 for one cycle.
- Accept: an edge in IDLE with start=1 latches Address, Reg_data and SS_control, and loads Mem_addr with Address. Inputs are don't-care after accept.
- Transitions from IDLE on accept:
  - 00 -> DONE (no memory activity, Mem_wr stays 0).
  - 11 -> WRITE; Mem_wdata=Reg_data.
  - 01 or 10 -> READ.
- READ: stays MEM_LATENCY cycles. On the last READ edge, Mem_rdata is sampled and merged; the state moves to WRITE with Mem_wdata loaded:
  - SB: {Mem_rdata[31:8], Reg_data[7:0]}
  - SH: {Mem_rdata[31:16], Reg_data[15:0]}
- WRITE -> DONE unconditionally. DONE -> IDLE unconditionally.
- Latency, counted in cycles after the accepting edge:
  - 00: done in cycle 1.
  - SW: Mem_wr in cycle 1, done in cycle 2.
  - SB/SH: Mem_wr in cycle MEM_LATENCY+1, done in cycle MEM_LATENCY+2.
- A new start is accepted no earlier than the edge that ends DONE. start is not sampled during that edge, so the minimum gap is one IDLE cycle.
- start while busy=1 is ignored; no queueing.
- Mem_addr holds the latched address from accept through DONE and keeps its last value in IDLE. Mem_wdata keeps its last value outside WRITE.
- Reset in any state, including the WRITE cycle's edge: next cycle is IDLE with Mem_wr=0. No write occurs after reset; done is not asserted for the aborted request.
- reset and start in the same cycle: reset wins; the request is dropped.
- No alignment checking; Address is passed through unchanged. The low byte/halfword position always matches the load unit's extraction (bits 7:0 / 15:0).

Test Plan:
- SB, MEM_LATENCY=1, memory word 0xAABBCCDD at 0x40, Reg_data=0x12345678:
  - Mem_addr=0x40 from cycle 1.
  - Mem_wr=1 only in cycle 2 with Mem_wdata=0xAABBCC78.
  - done in cycle 3; busy high cycles 1-3.
- SH, same setup:
  - Mem_wdata=0xAABB5678.
- SH with MEM_LATENCY=3:
  - Mem_wr in cycle 4, done in cycle 5.
  - Mem_rdata changed to garbage before cycle 3's edge produces a wrong merge, confirming the sample point.
- SW, Reg_data=0xDEADBEEF, Address=0x80:
  - Mem_wr in cycle 1 only, Mem_wdata=0xDEADBEEF.
  - done in cycle 2; memory is never read.
- SS_control=00:
  - done in cycle 1, Mem_wr never asserted.
  - start pulsed during busy (any size) is ignored: exactly one write and one done per accepted request.
- Reset asserted at the edge entering WRITE for an SB:
  - Mem_wr=0 throughout, no done, busy=0 next cycle.
  - A new SW started two cycles later completes normally.
